// File: rtl/i2c_slave.sv
// I2C target with oversampled SCL/SDA, 7-bit addressing and open-drain SDA.
// Bytes are handed to the host through rx_valid/rx_data and fetched via tx_req/tx_data.
//
// state        | meaning
// ST_IDLE      | bus free or not addressed, waiting for START
// ST_ADDR      | shifting in address + rw byte
// ST_ADDR_ACK  | driving ACK for a matched address
// ST_RX        | receiving a data byte from the master
// ST_RX_ACK    | driving ACK for a received byte
// ST_TX        | shifting a data byte out to the master
// ST_TX_ACK    | sampling the master's ACK/NACK
// ST_WAIT_STOP | not ours or NACKed; ignore bits until START/STOP
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h1A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_WAIT_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s, scl_d, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       tx_req_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // Requiring scl high on both samples keeps a coincident scl edge from faking a condition.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '1;
      shift_q    <= '1;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    tx_req_c   = 1'b0;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: sda_oe_d = 1'b0;

        ST_ADDR: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (shift_q[7:1] == ADDR) begin
              state_d  = ST_ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end

        // shift_q[0] still holds rw here.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (shift_q[0]) begin
              state_d  = ST_TX;
              tx_req_c = 1'b1;
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              cnt_d    = 4'd1;
            end else begin
              state_d = ST_RX;
              cnt_d   = 4'd0;
            end
          end
        end

        ST_RX: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d    = ST_RX_ACK;
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            sda_oe_d   = 1'b1;
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            state_d  = ST_RX;
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
          end
        end

        ST_TX: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = ST_TX_ACK;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[6:0], 1'b1};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end

        // cnt_q == 9 marks an ACK seen on the rising edge.
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end else begin
              cnt_d = 4'd9;
            end
          end else if (scl_fall && cnt_q == 4'd9) begin
            state_d  = ST_TX;
            tx_req_c = 1'b1;
            shift_d  = tx_data;
            sda_oe_d = ~tx_data[7];
            cnt_d    = 4'd1;
          end
        end

        ST_WAIT_STOP: sda_oe_d = 1'b0;

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign tx_req   = tx_req_c & ~rst;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, vector table, random transfers
// checked against a transaction-level model, and hand-written corner sequences.
module tb_i2c_slave;
  localparam logic [6:0] ADDR = 7'h1A;
  localparam int HP = 10;
  localparam int Q  = HP / 2;

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    int          n;
    logic [31:0] data;
    logic        exp_ack;
    int          exp_rx;
    int          exp_txreq;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       m_oe;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  wire        sda;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  i2c_slave #(.ADDR(ADDR)) dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda(sda),
    .tx_data(tx_data), .tx_req(tx_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rx_cnt = 0, txr_cnt = 0, txr_done = 0, drive_cnt = 0, busy_low = 0;
  logic [7:0] rx_log[$];
  logic [7:0] tx_vals[4];

  assign tx_data = tx_vals[txr_done[1:0]];

  // Observation happens 2 ns after the active edge; the master drives on the falling edge.
  always @(posedge clk) begin
    #2;
    if (rx_valid) begin
      rx_cnt++;
      rx_log.push_back(rx_data);
    end
    if (tx_req) txr_cnt++;
    if (!m_oe && sda == 1'b0) drive_cnt++;
    if (!busy) busy_low++;
  end

  always @(posedge clk) txr_done <= txr_cnt;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    m_oe = ~b;
    clks(Q);
    scl_m = 1'b1;
    clks(Q);
    r = sda;
    clks(Q);
    scl_m = 1'b0;
    clks(Q);
  endtask

  task automatic i2c_start();
    m_oe = 1'b0;
    clks(Q);
    scl_m = 1'b1;
    clks(HP);
    m_oe = 1'b1;
    clks(HP);
    scl_m = 1'b0;
    clks(Q);
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1;
    clks(Q);
    scl_m = 1'b1;
    clks(HP);
    m_oe = 1'b0;
    clks(HP);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(~mack, r);
  endtask

  // Transaction-level expectation: only our address is acknowledged; a write
  // delivers every byte to the host, a read fetches one host byte per data byte.
  function automatic vec_t ref_model(input logic [6:0] a, input logic rw, input int n,
                                     input logic [31:0] d);
    vec_t v;
    v.addr      = a;
    v.rw        = rw;
    v.n         = n;
    v.data      = d;
    v.exp_ack   = (a == ADDR);
    v.exp_rx    = (v.exp_ack && !rw) ? n : 0;
    v.exp_txreq = (v.exp_ack && rw) ? n : 0;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    int rx0, tq0, dr0, nacks;
    logic ack, dack, bmid, bend;
    logic [7:0] b;
    logic [31:0] rd, mask;
    rx0 = rx_cnt; tq0 = txr_cnt; dr0 = drive_cnt;
    nacks = 0; rd = '0;
    if (v.rw) for (int i = 0; i < v.n; i++) tx_vals[(txr_cnt + i) & 3] = v.data[31 - 8*i -: 8];
    i2c_start();
    write_byte({v.addr, v.rw}, ack);
    bmid = busy;
    for (int i = 0; i < v.n; i++) begin
      if (!v.rw) begin
        write_byte(v.data[31 - 8*i -: 8], dack);
        if (!dack) nacks++;
      end else if (ack) begin
        read_byte(i != v.n - 1, b);
        rd[31 - 8*i -: 8] = b;
      end
    end
    bend = busy;
    i2c_stop();
    mask = 32'hFFFF_FFFF << (32 - 8 * v.n);
    check({tag, "_ack"}, ack, v.exp_ack);
    check({tag, "_busy_mid"}, bmid, v.exp_ack);
    check({tag, "_busy_end"}, bend, v.exp_ack && !v.rw);
    check({tag, "_rx_count"}, rx_cnt - rx0, v.exp_rx);
    check({tag, "_txreq_count"}, txr_cnt - tq0, v.exp_txreq);
    for (int i = 0; i < v.exp_rx; i++)
      check({tag, "_rx_data"}, rx_log[rx0 + i], v.data[31 - 8*i -: 8]);
    if (v.rw && v.exp_ack) check({tag, "_read_data"}, rd, v.data & mask);
    if (!v.exp_ack) check({tag, "_no_drive"}, drive_cnt - dr0, 0);
    if (!v.rw) check({tag, "_wr_nacks"}, nacks, v.exp_ack ? 0 : v.n);
    check({tag, "_busy_after_stop"}, busy, 0);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;
    int rx0, tq0, dr0, bl0;
    logic ack, ack2, ack3, r;
    logic [7:0] b;
    logic [7:0] ab;

    vecs[0] = '{7'h1A, 1'b0, 1, 32'hA500_0000, 1'b1, 1, 0};
    vecs[1] = '{7'h1B, 1'b0, 1, 32'h5A00_0000, 1'b0, 0, 0};
    vecs[2] = '{7'h1A, 1'b1, 2, 32'h3CC3_0000, 1'b1, 0, 2};
    vecs[3] = '{7'h00, 1'b0, 1, 32'hFF00_0000, 1'b0, 0, 0};
    vecs[4] = '{7'h1A, 1'b0, 3, 32'h00FF_8100, 1'b1, 3, 0};
    vecs[5] = '{7'h5A, 1'b1, 1, 32'h7700_0000, 1'b0, 0, 0};
    vecs[6] = '{7'h1A, 1'b1, 1, 32'hE100_0000, 1'b1, 0, 1};

    for (int i = 0; i < 4; i++) tx_vals[i] = 8'h00;
    rst = 1'b1; scl_m = 1'b1; m_oe = 1'b0;
    clks(4);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_tx_req", tx_req, 0);
    check("reset_busy", busy, 0);
    check("reset_sda", sda, 1);
    rst = 1'b0;
    clks(HP);

    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 14; i++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 1) == 1) ? ADDR : 7'($urandom_range(0, 127));
      v = ref_model(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), $urandom);
      apply_vec(v, $sformatf("rnd%0d", i));
    end

    // Write, repeated START, then a read; busy must not drop across the restart.
    rx0 = rx_cnt; tq0 = txr_cnt;
    tx_vals[txr_cnt & 3] = 8'h96;
    i2c_start();
    write_byte({ADDR, 1'b0}, ack);
    write_byte(8'h11, ack2);
    bl0 = busy_low;
    i2c_start();
    write_byte({ADDR, 1'b1}, ack3);
    check("rs_busy_held", busy_low - bl0, 0);
    read_byte(1'b0, b);
    i2c_stop();
    check("rs_wr_ack", {ack, ack2}, 2'b11);
    check("rs_rd_ack", ack3, 1);
    check("rs_rx_count", rx_cnt - rx0, 1);
    check("rs_rx_data", rx_log[rx0], 8'h11);
    check("rs_txreq_count", txr_cnt - tq0, 1);
    check("rs_read_data", b, 8'h96);
    check("rs_busy_after_stop", busy, 0);

    // STOP after 4 data bits: byte discarded, block idle.
    rx0 = rx_cnt;
    i2c_start();
    write_byte({ADDR, 1'b0}, ack);
    bit_xfer(1'b1, r); bit_xfer(1'b0, r); bit_xfer(1'b1, r); bit_xfer(1'b1, r);
    i2c_stop();
    check("ps_addr_ack", ack, 1);
    check("ps_rx_count", rx_cnt - rx0, 0);
    check("ps_busy", busy, 0);
    check("ps_sda_released", sda, 1);
    dr0 = drive_cnt;
    write_byte(8'hA5, ack);
    i2c_stop();
    check("ps_idle_no_ack", ack, 0);
    check("ps_idle_no_drive", drive_cnt - dr0, 0);
    check("ps_idle_rx_count", rx_cnt - rx0, 0);

    // Reset pulse while the address ACK is being driven.
    ab = {ADDR, 1'b0};
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(ab[i], r);
    m_oe = 1'b0;
    clks(Q);
    check("rr_ack_driven", sda, 0);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    check("rr_sda_released", sda, 1);
    check("rr_busy", busy, 0);
    check("rr_rx_data", rx_data, 8'h00);
    clks(Q - 1);
    scl_m = 1'b1;
    clks(HP);
    scl_m = 1'b0;
    clks(Q);
    i2c_stop();
    apply_vec(ref_model(ADDR, 1'b0, 1, 32'h5C00_0000), "rr_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
